// File: rtl/pass_gate_arbiter_pkg.sv
// Shared definitions for the pass-gate arbiter: FSM state encodings and the selector default pattern.
package pass_gate_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    localparam logic [3:0] IDLE_PAT_DFLT = 4'b0101;

endpackage

// File: rtl/pass_gate_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping NREQ-1 -> 0.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx
);

    int          j;
    logic [IW-1:0] jj;
    logic        found;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = IW'(j);
            if (!found && req[jj]) begin
                found    = 1'b1;
                pick[jj] = 1'b1;
                idx      = jj;
            end
        end
    end

endmodule

// File: rtl/pass_gate_arbiter.sv
// Round-robin arbiter/sequencer sharing one pass/default selector among NREQ requesters.
// Optional PASS_GATE_PARITY_EN adds a registered even-parity output dout_par.
//
// state   | meaning
// IDLE    | no owner; arbitrate on |req, grant lands next cycle
// GRANT   | owner drives the selector, one beat per cycle while req held
// HOLDOFF | single dead cycle after release before re-arbitration
module pass_gate_arbiter
    import pass_gate_arbiter_pkg::*;
#(
    parameter int             NREQ      = 4,
    parameter int             DW        = 4,
    parameter int             CW        = 6,
    parameter int             MAX_BURST = 4,
    parameter logic [DW-1:0]  IDLE_PAT  = DW'(IDLE_PAT_DFLT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     last,
    input  logic [NREQ*DW-1:0]  data_in,
    output logic [NREQ-1:0]     gnt,
    output logic [DW-1:0]       sel_data,
    output logic [CW-1:0]       sel_ctrl,
    output logic [DW-1:0]       dout,
    output logic                dout_valid
`ifdef PASS_GATE_PARITY_EN
    ,
    output logic                dout_par
`endif
);

    localparam int            IW        = $clog2(NREQ);
    localparam logic [CW-1:0] CTRL_PASS = {CW{1'b1}};
    localparam logic [CW-1:0] CTRL_DFLT = {CW{1'b0}};

    logic [1:0]      state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [3:0]      beat_cnt;
    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic [DW-1:0]   data_arr [NREQ];
    logic [DW-1:0]   owner_data;
    logic [DW-1:0]   dout_nxt;
    logic [IW-1:0]   next_ptr;
    logic            in_grant;
    logic            owner_req;
    logic            beat;
    logic            release_now;

    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign data_arr[i] = data_in[i*DW +: DW];
    end

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .pick (pick_oh),
        .idx  (pick_idx)
    );

    assign in_grant    = (state == ST_GRANT);
    assign owner_data  = data_arr[owner];
    assign owner_req   = req[owner];
    assign beat        = in_grant & gnt[owner] & owner_req;
    // Abort (owner dropped req) takes precedence over last/forced release.
    assign release_now = in_grant & (~owner_req |
                         (beat & (last[owner] | (beat_cnt == 4'(MAX_BURST-1)))));
    assign next_ptr    = (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;
    assign dout_nxt    = beat ? owner_data : IDLE_PAT;

    assign sel_ctrl = in_grant ? CTRL_PASS : CTRL_DFLT;
    assign sel_data = in_grant ? owner_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            owner      <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            dout       <= IDLE_PAT;
            dout_valid <= 1'b0;
        end else begin
            dout       <= dout_nxt;
            dout_valid <= beat;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        owner <= pick_idx;
                        gnt   <= pick_oh;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        gnt      <= '0;
                        beat_cnt <= '0;
                        rr_ptr   <= next_ptr;
                        state    <= ST_HOLDOFF;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                ST_HOLDOFF: state <= ST_IDLE;
                default: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PASS_GATE_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) dout_par <= ^IDLE_PAT;
        else       dout_par <= ^dout_nxt;
    end
`endif

endmodule
